// File: rtl/value_bias_add_stream_if.sv
// Stream bundle for value_bias_add_stream: data_in and bias inputs, registered data_out.
// BIAS_ADD_SATURATE_EN adds the sat_flag output.
interface value_bias_add_stream_if #(
  parameter int unsigned DATA_IN_PRECISION_0  = 16,
  parameter int unsigned BIAS_PRECISION_0     = 16,
  parameter int unsigned DATA_OUT_PRECISION_0 = 16,
  parameter int unsigned PARALLELISM          = 1
);
  logic [PARALLELISM*DATA_IN_PRECISION_0-1:0]  data_in;
  logic                                        data_in_valid;
  logic                                        data_in_ready;
  logic [PARALLELISM*BIAS_PRECISION_0-1:0]     bias;
  logic                                        bias_valid;
  logic                                        bias_ready;
  logic [PARALLELISM*DATA_OUT_PRECISION_0-1:0] data_out;
  logic                                        data_out_valid;
  logic                                        data_out_ready;
  logic                                        data_out_last;
`ifdef BIAS_ADD_SATURATE_EN
  logic                                        sat_flag;

  modport master (
    output data_in, data_in_valid, input data_in_ready,
    output bias, bias_valid, input bias_ready,
    input data_out, data_out_valid, data_out_last, sat_flag, output data_out_ready
  );
  modport slave (
    input data_in, data_in_valid, output data_in_ready,
    input bias, bias_valid, output bias_ready,
    output data_out, data_out_valid, data_out_last, sat_flag, input data_out_ready
  );
`else
  modport master (
    output data_in, data_in_valid, input data_in_ready,
    output bias, bias_valid, input bias_ready,
    input data_out, data_out_valid, data_out_last, output data_out_ready
  );
  modport slave (
    input data_in, data_in_valid, output data_in_ready,
    input bias, bias_valid, output bias_ready,
    output data_out, data_out_valid, data_out_last, input data_out_ready
  );
`endif
endinterface

// File: rtl/value_bias_add_stream.sv
// Joins matmul results with bias beat by beat, adds in signed fixed point, and emits
// registered sums with a row-end marker. BIAS_ADD_SATURATE_EN selects clamping + sat_flag.
module value_bias_add_stream #(
  parameter int unsigned DATA_IN_PRECISION_0  = 16,
  parameter int unsigned DATA_IN_PRECISION_1  = 8,
  parameter int unsigned BIAS_PRECISION_0     = 16,
  parameter int unsigned BIAS_PRECISION_1     = 3,
  parameter int unsigned DATA_OUT_PRECISION_0 = 16,
  parameter int unsigned PARALLELISM          = 1,
  parameter int unsigned TENSOR_SIZE_DIM_0    = 32
) (
  input logic                    clk,
  input logic                    rst,
  value_bias_add_stream_if.slave io_bus
);
  localparam int unsigned DI_W  = DATA_IN_PRECISION_0;
  localparam int unsigned B_W   = BIAS_PRECISION_0;
  localparam int unsigned DO_W  = DATA_OUT_PRECISION_0;
  localparam int unsigned PAR   = PARALLELISM;
  localparam int unsigned DEPTH = TENSOR_SIZE_DIM_0 / PARALLELISM;
  localparam int unsigned SHIFT = DATA_IN_PRECISION_1 - BIAS_PRECISION_1;
  localparam int unsigned BAL_W = B_W + SHIFT;
  localparam int unsigned SUM_W = ((DI_W > BAL_W) ? DI_W : BAL_W) + 1;
  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef BIAS_ADD_SATURATE_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (DO_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef struct packed {
    logic [PAR*DO_W-1:0] data;
    logic                last;
    logic                sat;
  } beat_t;
`else
  typedef struct packed {
    logic [PAR*DO_W-1:0] data;
    logic                last;
  } beat_t;
`endif

  // Full-precision lane sum; SUM_W is wide enough that it never overflows.
  function automatic logic signed [SUM_W-1:0] lane_sum(input logic signed [DI_W-1:0] d,
                                                       input logic signed [B_W-1:0]  b);
    return SUM_W'(d) + (SUM_W'(b) <<< SHIFT);
  endfunction

  beat_t             r_out;
  logic              r_out_valid;
  beat_t             r_skid;
  logic              r_skid_valid;
  logic [CNT_W-1:0]  r_beat_cnt;

  beat_t             w_beat;
  logic              w_accept;
  logic              w_out_free;
`ifdef BIAS_ADD_SATURATE_EN
  logic signed [SUM_W-1:0] w_sum;
`endif

  assign w_accept   = io_bus.data_in_valid & io_bus.bias_valid & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | io_bus.data_out_ready;

  // Result for the beat being accepted this cycle.
  always_comb begin
    w_beat      = '0;
    w_beat.last = (r_beat_cnt == CNT_W'(DEPTH - 1));
`ifdef BIAS_ADD_SATURATE_EN
    w_sum = '0;
`endif
    for (int l = 0; l < PAR; l++) begin
`ifdef BIAS_ADD_SATURATE_EN
      w_sum = lane_sum(io_bus.data_in[l*DI_W +: DI_W], io_bus.bias[l*B_W +: B_W]);
      if (w_sum > SAT_MAX) begin
        w_beat.data[l*DO_W +: DO_W] = DO_W'(SAT_MAX);
        w_beat.sat                  = 1'b1;
      end else if (w_sum < SAT_MIN) begin
        w_beat.data[l*DO_W +: DO_W] = DO_W'(SAT_MIN);
        w_beat.sat                  = 1'b1;
      end else begin
        w_beat.data[l*DO_W +: DO_W] = DO_W'(w_sum);
      end
`else
      w_beat.data[l*DO_W +: DO_W] =
        DO_W'(lane_sum(io_bus.data_in[l*DI_W +: DI_W], io_bus.bias[l*B_W +: B_W]));
`endif
    end
  end

  // Output register with one-entry skid; the skid always drains before newer beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) r_out <= w_beat;
        end
      end else if (w_accept) begin
        r_skid       <= w_beat;
        r_skid_valid <= 1'b1;
      end
      if (w_accept) r_beat_cnt <= w_beat.last ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  assign io_bus.data_in_ready  = io_bus.bias_valid & ~r_skid_valid;
  assign io_bus.bias_ready     = io_bus.data_in_valid & ~r_skid_valid;
  assign io_bus.data_out       = r_out.data;
  assign io_bus.data_out_valid = r_out_valid;
  assign io_bus.data_out_last  = r_out.last;
`ifdef BIAS_ADD_SATURATE_EN
  assign io_bus.sat_flag       = r_out.sat;
`endif

endmodule
